// File: rtl/egg_gen.sv
// Egg spawner for the hit-egg game: one round of ROUND_EGGS eggs at pseudo-random holes.
// Latency: every output is registered; an egg appears or clears on the edge after its cause.
// Backpressure: none; tick is a free-running timebase and key is sampled every cycle in SHOW.
module egg_gen #(
   parameter int unsigned HOLD_TICKS = 20,
   parameter int unsigned GAP_TICKS  = 5,
   parameter int unsigned ROUND_EGGS = 30,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        tick_i,
   input  logic [16:0] key_i,
   output logic [16:0] position_o,
   output logic [1:0]  color_o,
   output logic        over_o,
   output logic [5:0]  eggs_left_o,
   output logic [4:0]  miss_cnt_o
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GAP,
      ST_SHOW,
      ST_DONE
   } state_t;

   localparam logic [7:0] GAP_LAST   = 8'(GAP_TICKS - 1);
   localparam logic [7:0] HOLD_LAST  = 8'(HOLD_TICKS - 1);
   localparam logic [5:0] ROUND_LOAD = 6'(ROUND_EGGS);
   localparam logic [4:0] IDX_NONE   = 5'd31;
   localparam logic [4:0] MISS_MAX   = 5'd31;
   localparam logic [4:0] HOLES      = 5'd17;
   localparam logic [4:0] LAST_HOLE  = 5'd16;

   state_t      state_q, state_d;
   logic [7:0]  tick_cnt_q, tick_cnt_d;
   logic [5:0]  eggs_left_q, eggs_left_d;
   logic [4:0]  miss_cnt_q, miss_cnt_d;
   logic [16:0] position_q, position_d;
   logic [1:0]  color_q, color_d;
   logic        over_q, over_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [4:0]  prev_idx_q, prev_idx_d;

   logic [4:0]  raw_idx;
   logic [4:0]  fold_idx;
   logic [4:0]  egg_idx;
   logic [16:0] egg_position;
   logic [1:0]  egg_color;
   logic        hit;
   logic        timeout;

   // LFSR next value: x^16+x^14+x^13+x^11+1, shifting every clock regardless of state
   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   // Candidate egg from the current LFSR value: fold 17..31 down, step off the previous hole
   always_comb begin
      raw_idx   = lfsr_q[4:0];
      fold_idx  = raw_idx;
      egg_idx   = 5'd0;
      egg_color = lfsr_q[6:5];
      if (raw_idx >= HOLES) begin
         fold_idx = raw_idx - HOLES;
      end
      egg_idx = fold_idx;
      if (fold_idx == prev_idx_q) begin
         egg_idx = (fold_idx == LAST_HOLE) ? 5'd0 : fold_idx + 5'd1;
      end
      if (lfsr_q[6:5] == 2'b00) begin
         egg_color = 2'b10;
      end
      egg_position = 17'd1 << egg_idx;
   end

   // Egg end conditions; a hit on the timeout edge is still a hit
   always_comb begin
      hit     = (key_i == position_q);
      timeout = tick_i && (tick_cnt_q == HOLD_LAST);
   end

   // Round sequencing: next state, counters and the visible egg
   always_comb begin
      state_d     = state_q;
      tick_cnt_d  = tick_cnt_q;
      eggs_left_d = eggs_left_q;
      miss_cnt_d  = miss_cnt_q;
      position_d  = position_q;
      color_d     = color_q;
      prev_idx_d  = prev_idx_q;
      over_d      = over_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               state_d     = ST_GAP;
               eggs_left_d = ROUND_LOAD;
               miss_cnt_d  = 5'd0;
               tick_cnt_d  = 8'd0;
               prev_idx_d  = IDX_NONE;
               position_d  = 17'd0;
               color_d     = 2'b00;
            end
         end
         ST_GAP: begin
            if (tick_i) begin
               if (tick_cnt_q == GAP_LAST) begin
                  state_d    = ST_SHOW;
                  tick_cnt_d = 8'd0;
                  position_d = egg_position;
                  color_d    = egg_color;
                  prev_idx_d = egg_idx;
               end else begin
                  tick_cnt_d = tick_cnt_q + 8'd1;
               end
            end
         end
         ST_SHOW: begin
            if (hit || timeout) begin
               position_d  = 17'd0;
               color_d     = 2'b00;
               tick_cnt_d  = 8'd0;
               eggs_left_d = eggs_left_q - 6'd1;
               if (!hit && (miss_cnt_q != MISS_MAX)) begin
                  miss_cnt_d = miss_cnt_q + 5'd1;
               end
               state_d = (eggs_left_q == 6'd1) ? ST_DONE : ST_GAP;
            end else if (tick_i) begin
               tick_cnt_d = tick_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      over_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
   end

   // State and output registers; reset drops any visible egg immediately
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         tick_cnt_q  <= 8'd0;
         eggs_left_q <= 6'd0;
         miss_cnt_q  <= 5'd0;
         position_q  <= 17'd0;
         color_q     <= 2'b00;
         over_q      <= 1'b1;
         lfsr_q      <= LFSR_SEED;
         prev_idx_q  <= IDX_NONE;
      end else begin
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         eggs_left_q <= eggs_left_d;
         miss_cnt_q  <= miss_cnt_d;
         position_q  <= position_d;
         color_q     <= color_d;
         over_q      <= over_d;
         lfsr_q      <= lfsr_d;
         prev_idx_q  <= prev_idx_d;
      end
   end

   assign position_o  = position_q;
   assign color_o     = color_q;
   assign over_o      = over_q;
   assign eggs_left_o = eggs_left_q;
   assign miss_cnt_o  = miss_cnt_q;

endmodule

// File: tb/tb_egg_gen.sv
module tb_egg_gen;

   localparam int HOLD  = 4;
   localparam int GAP   = 2;
   localparam int ROUND = 40;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        tick = 1'b0;
   logic [16:0] key = '0;
   logic [16:0] position_o;
   logic [1:0]  color_o;
   logic        over_o;
   logic [5:0]  eggs_left_o;
   logic [4:0]  miss_cnt_o;

   egg_gen #(
      .HOLD_TICKS(HOLD),
      .GAP_TICKS (GAP),
      .ROUND_EGGS(ROUND),
      .LFSR_SEED (16'hACE1)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .tick_i     (tick),
      .key_i      (key),
      .position_o (position_o),
      .color_o    (color_o),
      .over_o     (over_o),
      .eggs_left_o(eggs_left_o),
      .miss_cnt_o (miss_cnt_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model of the round, in terms of "round running", "egg visible" and tick counts
   bit          m_active;
   bit          m_shown;
   bit          m_loaded;
   int          m_cnt;
   int          m_left;
   int          m_miss;
   logic [16:0] m_pos;
   logic [1:0]  m_col;

   task model_reset();
      m_active = 0; m_shown = 0; m_loaded = 0;
      m_cnt = 0; m_left = 0; m_miss = 0;
      m_pos = '0; m_col = 2'b00;
   endtask

   // One clock: drive inputs, advance the model on the edge, sample #1 later
   task step(input bit s, input bit t, input logic [16:0] k);
      bit is_hit;
      bit is_tmo;
      start = s; tick = t; key = k;
      @(posedge clk);
      m_loaded = 0;
      if (!m_active) begin
         if (s) begin
            m_active = 1; m_shown = 0; m_cnt = 0; m_left = ROUND; m_miss = 0;
         end
      end else if (!m_shown) begin
         if (t) begin
            if (m_cnt == GAP - 1) begin
               m_shown = 1; m_cnt = 0; m_loaded = 1;
            end else begin
               m_cnt++;
            end
         end
      end else begin
         is_hit = (k == m_pos);
         is_tmo = t && (m_cnt == HOLD - 1);
         if (is_hit || is_tmo) begin
            m_shown = 0; m_cnt = 0; m_pos = '0; m_col = 2'b00;
            if (!is_hit && m_miss < 31) m_miss++;
            m_left--;
            if (m_left == 0) m_active = 0;
         end else if (t) begin
            m_cnt++;
         end
      end
      #1;
      if (m_loaded) begin
         m_pos = position_o; m_col = color_o;
      end
      start = 0; tick = 0; key = '0;
   endtask

   task test_reset();
      int c;
      int bad;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (position_o !== 17'd0) $display("FAIL reset_position: got %h want 0", position_o); else n_pass++;
      n_checks++; if (color_o !== 2'b00) $display("FAIL reset_color: got %b want 00", color_o); else n_pass++;
      n_checks++; if (over_o !== 1'b1) $display("FAIL reset_over: got %b want 1", over_o); else n_pass++;
      n_checks++; if (eggs_left_o !== 6'd0) $display("FAIL reset_eggs_left: got %0d want 0", eggs_left_o); else n_pass++;
      n_checks++; if (miss_cnt_o !== 5'd0) $display("FAIL reset_miss: got %0d want 0", miss_cnt_o); else n_pass++;
      rst = 1'b0;
      model_reset();

      step(1, 0, '0);
      c = 0;
      while (!m_shown && c < 100) begin
         step(0, 1, '0);
         c++;
      end
      n_checks++; if (!m_shown || position_o === 17'd0) $display("FAIL reset_reach_show: got position %h want visible egg", position_o); else n_pass++;

      // asynchronous reset mid-SHOW, observed before the next clock edge
      #1 rst = 1'b1;
      #1;
      n_checks++; if (position_o !== 17'd0) $display("FAIL midshow_rst_position: got %h want 0", position_o); else n_pass++;
      n_checks++; if (color_o !== 2'b00) $display("FAIL midshow_rst_color: got %b want 00", color_o); else n_pass++;
      n_checks++; if (over_o !== 1'b1) $display("FAIL midshow_rst_over: got %b want 1", over_o); else n_pass++;
      n_checks++; if (eggs_left_o !== 6'd0) $display("FAIL midshow_rst_eggs_left: got %0d want 0", eggs_left_o); else n_pass++;
      model_reset();
      #1 rst = 1'b0;

      bad = 0;
      repeat (100) begin
         step(0, 1, 17'($urandom));
         if (over_o !== 1'b1 || position_o !== 17'd0 || color_o !== 2'b00 || eggs_left_o !== 6'd0) bad++;
      end
      n_checks++; if (bad !== 0) $display("FAIL idle_hold: bad cycles got %0d want 0", bad); else n_pass++;
   endtask

   task test_all_miss();
      int c;
      step(1, 0, '0);
      n_checks++; if (over_o !== 1'b0) $display("FAIL start_over: got %b want 0", over_o); else n_pass++;
      n_checks++; if (eggs_left_o !== 6'(ROUND)) $display("FAIL start_eggs_left: got %0d want %0d", eggs_left_o, ROUND); else n_pass++;
      n_checks++; if (position_o !== 17'd0) $display("FAIL start_position: got %h want 0", position_o); else n_pass++;
      c = 0;
      while (m_active && c < 4000) begin
         step(0, 1'($urandom_range(0, 1)), '0);
         n_checks++; if ((position_o !== 17'd0) !== m_shown) $display("FAIL miss_visible: got %h want shown=%0d", position_o, m_shown); else n_pass++;
         if (m_shown) begin
            n_checks++; if (position_o !== m_pos) $display("FAIL miss_hold: got %h want %h", position_o, m_pos); else n_pass++;
         end
         n_checks++; if (eggs_left_o !== 6'(m_left)) $display("FAIL miss_eggs_left: got %0d want %0d", eggs_left_o, m_left); else n_pass++;
         n_checks++; if (miss_cnt_o !== 5'(m_miss)) $display("FAIL miss_count: got %0d want %0d", miss_cnt_o, m_miss); else n_pass++;
         n_checks++; if (over_o !== !m_active) $display("FAIL miss_over: got %b want %b", over_o, !m_active); else n_pass++;
         c++;
      end
      n_checks++; if (m_active) $display("FAIL miss_round_end: got still running want done within bound"); else n_pass++;
      n_checks++; if (miss_cnt_o !== 5'd31) $display("FAIL miss_saturate: got %0d want 31", miss_cnt_o); else n_pass++;
      n_checks++; if (eggs_left_o !== 6'd0) $display("FAIL done_eggs_left: got %0d want 0", eggs_left_o); else n_pass++;
      n_checks++; if (over_o !== 1'b1) $display("FAIL done_over: got %b want 1", over_o); else n_pass++;
   endtask

   task test_restart();
      int c;
      step(1, 0, '0);
      n_checks++; if (miss_cnt_o !== 5'd0) $display("FAIL restart_miss: got %0d want 0", miss_cnt_o); else n_pass++;
      n_checks++; if (eggs_left_o !== 6'(ROUND)) $display("FAIL restart_eggs_left: got %0d want %0d", eggs_left_o, ROUND); else n_pass++;
      n_checks++; if (over_o !== 1'b0) $display("FAIL restart_over: got %b want 0", over_o); else n_pass++;
      c = 0;
      while (!m_shown && c < 100) begin
         step(0, 1, '0);
         c++;
      end
      n_checks++; if (!m_shown) $display("FAIL restart_show: got no egg want egg within bound"); else n_pass++;
      step(1, 0, '0);
      n_checks++; if (position_o !== m_pos) $display("FAIL start_in_show_pos: got %h want %h", position_o, m_pos); else n_pass++;
      n_checks++; if (eggs_left_o !== 6'(ROUND)) $display("FAIL start_in_show_eggs: got %0d want %0d", eggs_left_o, ROUND); else n_pass++;
      n_checks++; if (over_o !== 1'b0) $display("FAIL start_in_show_over: got %b want 0", over_o); else n_pass++;
   endtask

   task test_hit();
      int c;
      int left_before;
      int miss_before;
      for (int h = 0; h < 3; h++) begin
         m_loaded = 0;
         c = 0;
         while (!m_loaded && c < 100) begin
            step(0, 1, '0);
            c++;
         end
         n_checks++; if (!m_loaded) $display("FAIL hit_wait_egg: got no egg want egg within bound"); else n_pass++;
         left_before = m_left;
         miss_before = m_miss;
         step(0, 0, position_o);
         n_checks++; if (position_o !== 17'd0) $display("FAIL hit_clear_pos: got %h want 0", position_o); else n_pass++;
         n_checks++; if (color_o !== 2'b00) $display("FAIL hit_clear_color: got %b want 00", color_o); else n_pass++;
         n_checks++; if (eggs_left_o !== 6'(left_before - 1)) $display("FAIL hit_eggs_left: got %0d want %0d", eggs_left_o, left_before - 1); else n_pass++;
         n_checks++; if (miss_cnt_o !== 5'(miss_before)) $display("FAIL hit_miss: got %0d want %0d", miss_cnt_o, miss_before); else n_pass++;
         n_checks++; if (over_o !== 1'b0) $display("FAIL hit_over: got %b want 0", over_o); else n_pass++;
      end
   endtask

   task test_simultaneous();
      int c;
      int left_before;
      int miss_before;
      for (int mode = 0; mode < 2; mode++) begin
         m_loaded = 0;
         c = 0;
         while (!m_loaded && c < 100) begin
            step(0, 1, '0);
            c++;
         end
         n_checks++; if (!m_loaded) $display("FAIL simul_wait_egg: got no egg want egg within bound"); else n_pass++;
         for (int i = 0; i < HOLD - 1; i++) step(0, 1, '0);
         n_checks++; if (position_o !== m_pos || m_pos === 17'd0) $display("FAIL simul_still_shown: got %h want %h", position_o, m_pos); else n_pass++;
         left_before = m_left;
         miss_before = m_miss;
         step(0, 1, (mode == 0) ? position_o : 17'd0);
         n_checks++; if (position_o !== 17'd0) $display("FAIL simul_clear_pos mode%0d: got %h want 0", mode, position_o); else n_pass++;
         n_checks++; if (eggs_left_o !== 6'(left_before - 1)) $display("FAIL simul_eggs_left mode%0d: got %0d want %0d", mode, eggs_left_o, left_before - 1); else n_pass++;
         n_checks++; if (miss_cnt_o !== 5'(miss_before + mode)) $display("FAIL simul_miss mode%0d: got %0d want %0d", mode, miss_cnt_o, miss_before + mode); else n_pass++;
      end
   endtask

   task test_legality();
      int c;
      int prev;
      int idx;
      logic [16:0] k;
      for (int r = 0; r < 11; r++) begin
         if (r > 0) step(1, 0, '0);
         prev = -1;
         c = 0;
         while (m_active && c < 3000) begin
            if (m_shown && $urandom_range(0, 3) == 0) k = position_o;
            else if ($urandom_range(0, 7) == 0) k = 17'($urandom);
            else k = '0;
            step(0, 1'($urandom_range(0, 1)), k);
            if (m_loaded) begin
               n_checks++; if (!$onehot(position_o)) $display("FAIL legal_onehot: got %h want one-hot", position_o); else n_pass++;
               n_checks++; if (color_o === 2'b00) $display("FAIL legal_color: got %b want nonzero", color_o); else n_pass++;
               idx = -1;
               for (int b = 0; b < 17; b++) if (position_o[b]) idx = b;
               n_checks++; if (idx == prev) $display("FAIL legal_repeat: got index %0d want differ from %0d", idx, prev); else n_pass++;
               prev = idx;
            end else if (!m_shown) begin
               n_checks++; if (position_o !== 17'd0 || color_o !== 2'b00) $display("FAIL legal_blank: got %h/%b want 0/00", position_o, color_o); else n_pass++;
            end else begin
               n_checks++; if (position_o !== m_pos || color_o !== m_col) $display("FAIL legal_hold: got %h/%b want %h/%b", position_o, color_o, m_pos, m_col); else n_pass++;
            end
            n_checks++; if (eggs_left_o !== 6'(m_left) || miss_cnt_o !== 5'(m_miss)) $display("FAIL legal_counts: got %0d/%0d want %0d/%0d", eggs_left_o, miss_cnt_o, m_left, m_miss); else n_pass++;
            c++;
         end
         n_checks++; if (m_active || over_o !== 1'b1) $display("FAIL legal_round_end: got over=%b want 1 within bound", over_o); else n_pass++;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      test_reset();
      test_all_miss();
      test_restart();
      test_hit();
      test_simultaneous();
      test_legality();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
